alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational 32-bit ALU (and/or/add/sub/slt, zero flag) among NREQ requesters.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin. Operands are held stable on the ALU for a programmable settle time. The result and zero flag are registered and returned to the winning requester.
- Sits between the datapath clients and the shared ALU instance.

Parameters:
- NREQ, 2, number of requesters (legal 2..4)
- SETTLE, 1, cycles the operands are held on the ALU before the result is captured (legal 1..7)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester request accepted
- req_a  in  32*NREQ  operand A, requester i in bits [32i+31:32i]
- req_b  in  32*NREQ  operand B, same packing as req_a
- req_op  in  3*NREQ  op code, requester i in bits [3i+2:3i]
- resp_valid  out  NREQ  per-requester response valid
- resp_ready  in  NREQ  per-requester response accept
- resp_z  out  32  result, shared by all requesters; qualified by resp_valid
- resp_zero  out  1  ALU zero flag for the result
- resp_err  out  1  illegal op flag
- alu_a  out  32  to ALU a
- alu_b  out  32  to ALU b
- alu_op  out  3  to ALU op
- alu_z  in  32  from ALU z
- alu_zero  in  1  from ALU zero
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async, rst_n=0) forces every output and register to zero:
  - req_ready, resp_valid, resp_z, resp_zero, resp_err, alu_a, alu_b, alu_op, busy all 0.
  - FSM enters IDLE; round-robin pointer resets to 0; settle counter resets to 0.
- Legal op codes: 000 and, 001 or, 010 add, 110 sub, 111 slt. Any other code is illegal.
- The FSM has three states.
- IDLE:
  - Scan req_valid starting at the pointer, wrapping modulo NREQ. The first asserted index wins.
  - req_ready[win] is asserted combinationally in IDLE only.
  - Handshake completes when req_valid & req_ready are both high on the same clock edge.
  - On completion: latch a, b, op into alu_a/alu_b/alu_op; record the winner; load the counter with SETTLE-1; go to EXEC.
  - If the op is illegal: skip EXEC, load resp_z=0, resp_zero=0, resp_err=1, and go to RESP.
- EXEC:
  - alu_* outputs are held constant for exactly SETTLE cycles; the counter decrements each cycle.
  - When the counter reaches 0: resp_z<=alu_z, resp_zero<=alu_zero, resp_err<=0; go to RESP.
- RESP:
  - resp_valid[winner]=1; all other resp_valid bits stay 0. resp_* are held stable.
  - When resp_ready[winner]=1: pointer <= (winner+1) mod NREQ; resp_valid drops; go to IDLE.
- Latency: request accept edge to resp_valid high is SETTLE+1 cycles for legal ops and 1 cycle for illegal ops.
- One transaction is in flight at a time. req_ready is 0 in EXEC and RESP.
- The earliest next accept is the cycle after the response handshake, so there is a 1-cycle IDLE gap.
- Fairness: a requester with continuous req_valid is granted within NREQ transactions.
- req_valid from a non-winner during EXEC/RESP is ignored. No request is dropped, because ready was never given to it.
- Requester-side change of req_* while valid and not ready is allowed. Only values at the accept edge are used.
- alu_a/alu_b/alu_op hold their last values in IDLE and RESP.
- rst_n asserted mid-EXEC or mid-RESP aborts the transaction; nothing is returned.
- busy = (state != IDLE).

Optional Feature:
- Macro: ALU_SHARE_ARBITER_LOCK_EN.
- When defined:
  - Adds input req_lock (NREQ bits).
  - If req_lock[winner]=1 at the response handshake, the pointer is not advanced, and the next IDLE grant goes to the winner if its req_valid is high; otherwise normal scan applies.
  - The lock is limited to 4 consecutive grants; the 5th forces pointer advance. The lock counter resets on any non-locked grant.
- When undefined: no req_lock port; pure round-robin.

Test Plan:
- Single add: req0 a=5, b=7, op=010, SETTLE=1 -> accept, resp_valid[0] 2 cycles later, resp_z=12, zero=0, err=0.
- Sub to zero and slt: req1 a=9, b=9, op=110 -> z=0, zero=1. Then a=0xFFFFFFFF, b=1, op=111 -> z=1.
- Contention: req0 and req1 valid together from reset, 4 ops each -> grants alternate 0,1,0,1…, and each resp_valid goes only to the winner.
- Backpressure: hold resp_ready[0]=0 for 10 cycles -> resp_valid/resp_z stable, req_ready all 0, busy=1 throughout.
- Illegal op 011 -> resp_valid after 1 cycle, resp_err=1, z=0. Also check that SETTLE=3 holds alu_* for 3 cycles.
- Reset mid-EXEC: assert rst_n=0 -> all outputs 0 immediately. A fresh request after release is served from pointer 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external combinational ALU among NREQ requesters, with a
// programmable operand settle time. Optional macro ALU_SHARE_ARBITER_LOCK_EN adds req_lock.
module alu_share_arbiter #(
    parameter int NREQ   = 2,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [32*NREQ-1:0] req_a,
    input  logic [32*NREQ-1:0] req_b,
    input  logic [3*NREQ-1:0]  req_op,
    output logic [NREQ-1:0]    resp_valid,
    input  logic [NREQ-1:0]    resp_ready,
    output logic [31:0]        resp_z,
    output logic               resp_zero,
    output logic               resp_err,
    output logic [31:0]        alu_a,
    output logic [31:0]        alu_b,
    output logic [2:0]         alu_op,
    input  logic [31:0]        alu_z,
    input  logic               alu_zero,
`ifdef ALU_SHARE_ARBITER_LOCK_EN
    input  logic [NREQ-1:0]    req_lock,
`endif
    output logic               busy
);
    localparam int PW = (NREQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t            state_q;
    logic [PW-1:0]     ptr_q, ptr_d, win_q, grant_idx, scan_idx;
    logic              grant_vld;
    logic [2:0]        cnt_q;
    logic [31:0]       alu_a_q, alu_b_q, resp_z_q;
    logic [2:0]        alu_op_q;
    logic              resp_zero_q, resp_err_q;
    logic [NREQ-1:0]   resp_valid_q;
    logic [31:0]       acc_a, acc_b;
    logic [2:0]        acc_op;
`ifdef ALU_SHARE_ARBITER_LOCK_EN
    logic [2:0]        lock_cnt_q, lock_cnt_d;
`endif

    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            3'b000, 3'b001, 3'b010, 3'b110, 3'b111: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    // Scan from the pointer downwards in offset so the smallest offset is written last and wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = ptr_q;
        scan_idx  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_idx = PW'((int'(ptr_q) + k) % NREQ);
            if (req_valid[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    always_comb begin
        acc_a  = req_a[31:0];
        acc_b  = req_b[31:0];
        acc_op = req_op[2:0];
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == PW'(i)) begin
                acc_a  = req_a[i*32 +: 32];
                acc_b  = req_b[i*32 +: 32];
                acc_op = req_op[i*3 +: 3];
            end
        end
    end

    // Gated by rst_n so ready is low while reset is held, even with requests pending.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state_q == S_IDLE) && grant_vld) req_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        ptr_d = (int'(win_q) == NREQ - 1) ? '0 : win_q + 1'b1;
`ifdef ALU_SHARE_ARBITER_LOCK_EN
        lock_cnt_d = '0;
        if (req_lock[win_q] && (lock_cnt_q < 3'd4)) begin
            ptr_d      = win_q;
            lock_cnt_d = lock_cnt_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            win_q        <= '0;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            resp_z_q     <= '0;
            resp_zero_q  <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_valid_q <= '0;
`ifdef ALU_SHARE_ARBITER_LOCK_EN
            lock_cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_vld) begin
                        alu_a_q  <= acc_a;
                        alu_b_q  <= acc_b;
                        alu_op_q <= acc_op;
                        win_q    <= grant_idx;
                        cnt_q    <= 3'(SETTLE - 1);
                        if (op_legal(acc_op)) begin
                            state_q <= S_EXEC;
                        end else begin
                            resp_z_q                <= '0;
                            resp_zero_q             <= 1'b0;
                            resp_err_q              <= 1'b1;
                            resp_valid_q[grant_idx] <= 1'b1;
                            state_q                 <= S_RESP;
                        end
                    end
                end
                S_EXEC: begin
                    if (cnt_q == 3'd0) begin
                        resp_z_q            <= alu_z;
                        resp_zero_q         <= alu_zero;
                        resp_err_q          <= 1'b0;
                        resp_valid_q[win_q] <= 1'b1;
                        state_q             <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready[win_q]) begin
                        ptr_q        <= ptr_d;
                        resp_valid_q <= '0;
                        state_q      <= S_IDLE;
`ifdef ALU_SHARE_ARBITER_LOCK_EN
                        lock_cnt_q   <= lock_cnt_d;
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign resp_z     = resp_z_q;
    assign resp_zero  = resp_zero_q;
    assign resp_err   = resp_err_q;
    assign resp_valid = resp_valid_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized self-checking bench for alu_share_arbiter against a transaction-level reference model.
module tb_alu_share_arbiter;
    localparam int NREQ = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [NREQ-1:0]     req_valid, req_ready, resp_valid, resp_ready;
    logic [32*NREQ-1:0]  req_a, req_b;
    logic [3*NREQ-1:0]   req_op;
    logic [31:0]         resp_z, alu_a, alu_b, alu_z;
    logic [2:0]          alu_op;
    logic                resp_zero, resp_err, alu_zero, busy;

    logic [31:0]         ta [NREQ];
    logic [31:0]         tb [NREQ];
    logic [2:0]          top[NREQ];

    // Second instance with a longer settle time
    logic [NREQ-1:0]     req_valid3, req_ready3, resp_valid3, resp_ready3;
    logic [32*NREQ-1:0]  req_a3, req_b3;
    logic [3*NREQ-1:0]   req_op3;
    logic [31:0]         resp_z3, alu_a3, alu_b3, alu_z3;
    logic [2:0]          alu_op3;
    logic                resp_zero3, resp_err3, alu_zero3, busy3;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit is_legal(input logic [2:0] op);
        return (op == 3'b000) || (op == 3'b001) || (op == 3'b010) || (op == 3'b110) || (op == 3'b111);
    endfunction

    always_comb begin
        req_a = '0;
        req_b = '0;
        req_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*32 +: 32] = ta[i];
            req_b[i*32 +: 32] = tb[i];
            req_op[i*3 +: 3]  = top[i];
        end
    end

    assign alu_z     = alu_f(alu_a, alu_b, alu_op);
    assign alu_zero  = (alu_z == 32'd0);
    assign alu_z3    = alu_f(alu_a3, alu_b3, alu_op3);
    assign alu_zero3 = (alu_z3 == 32'd0);

    alu_share_arbiter #(.NREQ(NREQ), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_z(resp_z), .resp_zero(resp_zero), .resp_err(resp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_z(alu_z), .alu_zero(alu_zero), .busy(busy)
    );

    alu_share_arbiter #(.NREQ(NREQ), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_a(req_a3), .req_b(req_b3), .req_op(req_op3),
        .resp_valid(resp_valid3), .resp_ready(resp_ready3),
        .resp_z(resp_z3), .resp_zero(resp_zero3), .resp_err(resp_err3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3),
        .alu_z(alu_z3), .alu_zero(alu_zero3), .busy(busy3)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int m_ptr  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] m);
        for (int k = 0; k < NREQ; k++)
            if (m[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        return 0;
    endfunction

    // One complete transaction on the SETTLE=1 instance; mask must be nonzero.
    task automatic txn(input logic [NREQ-1:0] mask, input int hold);
        int          w, lat;
        logic [31:0] ea, eb, ez;
        logic [2:0]  eo;
        bit          legal;
        @(negedge clk);
        req_valid = mask;
        #1;
        w     = pick(mask);
        ea    = ta[w];
        eb    = tb[w];
        eo    = top[w];
        legal = is_legal(eo);
        ez    = legal ? alu_f(ea, eb, eo) : 32'd0;
        chk("grant", 32'(req_ready), 32'(NREQ'(1) << w));
        @(posedge clk);
        @(negedge clk);
        req_valid &= ~(NREQ'(1) << w);
        lat = 1;
        while (resp_valid == '0 && lat < 20) begin
            chk("ready_exec", 32'(req_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), legal ? 32'd2 : 32'd1);
        chk("resp_valid", 32'(resp_valid), 32'(NREQ'(1) << w));
        chk("resp_z", resp_z, ez);
        chk("resp_zero", 32'(resp_zero), (legal && ez == 32'd0) ? 32'd1 : 32'd0);
        chk("resp_err", 32'(resp_err), legal ? 32'd0 : 32'd1);
        if (legal) chk("alu_a", alu_a, ea);
        resp_ready = ~(NREQ'(1) << w);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("bp_valid", 32'(resp_valid), 32'(NREQ'(1) << w));
            chk("bp_z", resp_z, ez);
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
        end
        resp_ready = NREQ'(1) << w;
        @(negedge clk);
        resp_ready = '0;
        req_valid  = '0;
        chk("resp_drop", 32'(resp_valid), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        m_ptr = (w + 1) % NREQ;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        ta[i]  = a;
        tb[i]  = b;
        top[i] = op;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        resp_ready = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, 32'd0, 32'd0, 3'd0);
        req_valid3 = '0; resp_ready3 = '0; req_a3 = '0; req_b3 = '0; req_op3 = '0;
        repeat (2) @(negedge clk);
        req_valid = '1;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        set_req(0, 32'd5, 32'd7, 3'b010);
        txn(2'b01, 0);
        set_req(1, 32'd9, 32'd9, 3'b110);
        txn(2'b10, 0);
        set_req(1, 32'hFFFF_FFFF, 32'd1, 3'b111);
        txn(2'b10, 0);

        for (int t = 0; t < 8; t++) begin
            set_req(0, $urandom, $urandom, 3'($urandom_range(0, 7)));
            set_req(1, $urandom, $urandom, 3'($urandom_range(0, 7)));
            txn(2'b11, 0);
        end

        set_req(0, 32'h1234_0000, 32'h0000_5678, 3'b001);
        txn(2'b01, 10);
        set_req(0, 32'd3, 32'd4, 3'b011);
        txn(2'b01, 0);

        // SETTLE=3: operands held for three cycles, response on the fourth
        @(negedge clk);
        req_a3 = {32'd0, 32'd100}; req_b3 = {32'd0, 32'd58}; req_op3 = {3'd0, 3'b110};
        req_valid3 = 2'b01;
        #1;
        chk("s3_grant", 32'(req_ready3), 32'd1);
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req_valid3 = '0;
            chk("s3_alu_a", alu_a3, 32'd100);
            chk("s3_alu_b", alu_b3, 32'd58);
            chk("s3_alu_op", 32'(alu_op3), 32'd6);
            chk("s3_wait", 32'(resp_valid3), 32'd0);
        end
        @(negedge clk);
        chk("s3_valid", 32'(resp_valid3), 32'd1);
        chk("s3_z", resp_z3, 32'd42);
        resp_ready3 = 2'b01;
        @(negedge clk);
        resp_ready3 = '0;

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                ta[i]  = $urandom;
                tb[i]  = ($urandom_range(0, 3) == 0) ? ta[i] : $urandom;
                top[i] = 3'($urandom_range(0, 7));
            end
            txn(NREQ'($urandom_range(1, 3)), $urandom_range(0, 3));
        end

        // Reset in the middle of EXEC, with the pointer away from 0
        set_req(0, 32'd1, 32'd1, 3'b010);
        set_req(1, 32'd2, 32'd2, 3'b010);
        if (m_ptr == 0) txn(2'b01, 0);
        @(negedge clk);
        req_valid = 2'b11;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_ready", 32'(req_ready), 32'd0);
        chk("mid_valid", 32'(resp_valid), 32'd0);
        chk("mid_alu_a", alu_a, 32'd0);
        chk("mid_alu_op", 32'(alu_op), 32'd0);
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;
        m_ptr = 0;
        txn(2'b11, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
